alu_op_sequencer: RTL



---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_cmd_fifo.sv | 52 +++++
 rtl/alu_op_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes and sequencer state encoding for the float ALU initiator.
package alu_pkg;

    localparam logic [3:0] ALU_OP_NOP = 4'b0000;
    localparam logic [3:0] ALU_OP_ADD = 4'b0001;
    localparam logic [3:0] ALU_OP_MUL = 4'b0010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_MUL);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO with registered full/empty flags; head entry is read combinationally.
module alu_cmd_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             do_push;
    logic             do_pop;

    // Push is gated by the registered full flag, so a same-cycle pop never frees a slot early.
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign count_next = count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    assign rd_data    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == (PTR_W+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for alu_e4m3/alu_bf16: queues (op, a, b) commands, issues one at a time,
// waits for is_output_valid with a timeout, and returns results in order.
//
//   state | meaning
//   IDLE  | nothing in flight, waiting for a queued command
//   ISSUE | operands driven, one-cycle ALU pipeline restart
//   WAIT  | operands held, waiting for alu_valid or timeout
//   DONE  | result presented, waiting for res_ready
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic             alu_reset,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_valid,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_y,
    output logic             res_err,
    output logic             busy
);

    localparam int CMD_W = 4 + 2*WIDTH;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    seq_state_e       state;
    logic [CNT_W-1:0] wait_cnt;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [CMD_W-1:0] head;
    logic [3:0]       head_op;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (cmd_valid),
        .pop     (fifo_pop),
        .wr_data ({cmd_op, cmd_a, cmd_b}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_op = head[CMD_W-1 -: 4];
    assign head_a  = head[2*WIDTH-1 -: WIDTH];
    assign head_b  = head[WIDTH-1:0];

    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    // Popping straight out of an accepted DONE avoids an IDLE bubble between commands.
    assign fifo_pop = !fifo_empty &&
                      ((state == IDLE) || ((state == DONE) && res_ready));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= ALU_OP_NOP;
            alu_reset <= 1'b0;
            res_valid <= 1'b0;
            res_y     <= '0;
            res_err   <= 1'b0;
        end else begin
            alu_reset <= 1'b0;

            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (alu_valid) begin
                        res_y     <= alu_y;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        alu_ctrl  <= ALU_OP_NOP;
                        state     <= DONE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT-1)) begin
                        res_y     <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        alu_ctrl  <= ALU_OP_NOP;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Head load overrides the case above in both IDLE and accepted DONE.
            if (fifo_pop) begin
                if (op_is_legal(head_op)) begin
                    alu_a     <= head_a;
                    alu_b     <= head_b;
                    alu_ctrl  <= head_op;
                    alu_reset <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ISSUE;
                end else begin
                    res_y     <= '0;
                    res_err   <= 1'b1;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
            end
        end
    end

endmodule
